// File: rtl/videocore_csr_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : videocore_csr_pkg
// Description : Shared constants and types for the video-core CSR responder:
//               register byte offsets, register bit positions and the
//               run-state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package videocore_csr_pkg;

    // Register byte offsets
    localparam logic [31:0] CSR_CONTROL = 32'h00;
    localparam logic [31:0] CSR_STATUS  = 32'h04;
    localparam logic [31:0] CSR_IRQ     = 32'h08;
    localparam logic [31:0] CSR_WIDTH   = 32'h0C;
    localparam logic [31:0] CSR_HEIGHT  = 32'h10;
    localparam logic [31:0] CSR_XOFF    = 32'h14;
    localparam logic [31:0] CSR_YOFF    = 32'h18;

    // Bit positions
    localparam int GO          = 0;   // CONTROL
    localparam int IRQ_EN      = 1;   // CONTROL
    localparam int STATUS_LOCK = 10;  // STATUS
    localparam int IRQ_FRAME   = 1;   // INTERRUPT

    typedef enum logic [1:0] {
        STOPPED  = 2'd0,
        RUNNING  = 2'd1,
        STOPPING = 2'd2
    } run_state_t;

endpackage
`default_nettype wire

// File: rtl/videocore_csr_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : videocore_csr_slave_if
// Description : Avalon-MM control bus between the configuration master and
//               the CSR responder.
//   amm_address/amm_write/amm_read/amm_writedata : master -> slave command
//   amm_waitrequest                              : slave command stall
//   amm_readdata/amm_readdatavalid               : slave read response
// Revision    : 1.0 - initial release
// ============================================================================
interface videocore_csr_slave_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] amm_address;
    logic              amm_write;
    logic              amm_read;
    logic [31:0]       amm_writedata;
    logic              amm_waitrequest;
    logic [31:0]       amm_readdata;
    logic              amm_readdatavalid;

    modport master (
        output amm_address, amm_write, amm_read, amm_writedata,
        input  amm_waitrequest, amm_readdata, amm_readdatavalid
    );

    modport slave (
        input  amm_address, amm_write, amm_read, amm_writedata,
        output amm_waitrequest, amm_readdata, amm_readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/videocore_csr_slave_csr_read_pipe.sv
`default_nettype none
// ============================================================================
// Module      : csr_read_pipe
// Description : DEPTH-stage valid/data shift register that delays captured
//               read data to the bus. Data travels zeroed when not valid, so
//               the output data is 0 whenever out_valid is 0.
//   clock, reset_n     : clock, asynchronous active-low reset
//   in_valid, in_data  : read accepted this cycle and its captured data
//   out_valid, out_data: response, DEPTH cycles after acceptance
// Revision    : 1.0 - initial release
// ============================================================================
module csr_read_pipe #(
    parameter int DEPTH = 2,   // legal range 1..4
    parameter int DATA_W = 32
) (
    input  wire logic              clock,
    input  wire logic              reset_n,
    input  wire logic              in_valid,
    input  wire logic [DATA_W-1:0] in_data,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data
);
    logic [DEPTH-1:0]  valid_q;
    logic [DATA_W-1:0] data_q [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q[0] <= 1'b0;
            data_q[0]  <= '0;
        end else begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_valid ? in_data : '0;
        end
    end

    generate
        for (genvar i = 1; i < DEPTH; i++) begin : g_stage
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    valid_q[i] <= 1'b0;
                    data_q[i]  <= '0;
                end else begin
                    valid_q[i] <= valid_q[i-1];
                    data_q[i]  <= data_q[i-1];
                end
            end
        end
    endgenerate

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
endmodule
`default_nettype wire

// File: rtl/videocore_csr_slave.sv
`default_nettype none
// ============================================================================
// Module      : videocore_csr_slave
// Description : Avalon-MM CSR responder for one video-core function. Holds a
//               shadow configuration (GO, geometry, offsets) and commits it
//               atomically to the active outputs at frame_start. Reports run
//               status, upstream lock and a sticky frame-done interrupt.
//   clock, reset_n         : clock, asynchronous active-low reset
//   bus                    : Avalon-MM slave port (command, stall, response)
//   frame_start/frame_done : single-cycle frame boundary pulses
//   locked                 : upstream timing stable
//   go, active_*           : committed configuration for the pixel pipeline
//   irq                    : level interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module videocore_csr_slave
    import videocore_csr_pkg::*;
#(
    parameter int ADDR_W       = 5,
    parameter int READ_LATENCY = 2,
    parameter int DIM_W        = 16
) (
    input  wire logic            clock,
    input  wire logic            reset_n,
    videocore_csr_slave_if.slave bus,
    input  wire logic            frame_start,
    input  wire logic            frame_done,
    input  wire logic            locked,
    output logic                 go,
    output logic [DIM_W-1:0]     active_width,
    output logic [DIM_W-1:0]     active_height,
    output logic [DIM_W-1:0]     active_x,
    output logic [DIM_W-1:0]     active_y,
    output logic                 irq
);
    // Command handshake: a command coinciding with a commit is held off one
    // cycle so the commit always sees a stable shadow set.
    logic        stall;
    logic        rd_acc;
    logic        wr_acc;
    logic [31:0] byte_addr;
    logic [31:0] wd;

    assign stall     = frame_start & (bus.amm_read | bus.amm_write);
    assign rd_acc    = bus.amm_read  & ~stall;
    assign wr_acc    = bus.amm_write & ~stall;
    assign byte_addr = 32'({bus.amm_address[ADDR_W-1:2], 2'b00});
    assign wd        = bus.amm_writedata;

    assign bus.amm_waitrequest = stall;

    logic unused_bits;
    assign unused_bits = ^{bus.amm_address[1:0], wd[31:DIM_W]};

    // Register state
    logic             ctrl_go;
    logic             ctrl_irq_en;
    logic             irq_frame;
    logic             locked_s;
    logic [DIM_W-1:0] shadow_w;
    logic [DIM_W-1:0] shadow_h;
    logic [DIM_W-1:0] shadow_x;
    logic [DIM_W-1:0] shadow_y;
    run_state_t       state;

    // Read mux sees pre-edge values, so a same-cycle write is not visible.
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (byte_addr)
            CSR_CONTROL: begin
                rd_mux[GO]     = ctrl_go;
                rd_mux[IRQ_EN] = ctrl_irq_en;
            end
            CSR_STATUS: begin
                rd_mux[0]           = (state != STOPPED);
                rd_mux[STATUS_LOCK] = locked_s;
            end
            CSR_IRQ:    rd_mux[IRQ_FRAME]   = irq_frame;
            CSR_WIDTH:  rd_mux[DIM_W-1:0]   = shadow_w;
            CSR_HEIGHT: rd_mux[DIM_W-1:0]   = shadow_h;
            CSR_XOFF:   rd_mux[DIM_W-1:0]   = shadow_x;
            CSR_YOFF:   rd_mux[DIM_W-1:0]   = shadow_y;
            default:    rd_mux              = '0;
        endcase
    end

    // Writable registers, lock sampling and interrupt
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_go     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            irq_frame   <= 1'b0;
            locked_s    <= 1'b0;
            irq         <= 1'b0;
            shadow_w    <= '0;
            shadow_h    <= '0;
            shadow_x    <= '0;
            shadow_y    <= '0;
        end else begin
            locked_s <= locked;
            irq      <= irq_frame & ctrl_irq_en;

            if (wr_acc) begin
                case (byte_addr)
                    CSR_CONTROL: begin
                        ctrl_go     <= wd[GO];
                        ctrl_irq_en <= wd[IRQ_EN];
                    end
                    CSR_WIDTH:  shadow_w <= wd[DIM_W-1:0];
                    CSR_HEIGHT: shadow_h <= wd[DIM_W-1:0];
                    CSR_XOFF:   shadow_x <= wd[DIM_W-1:0];
                    CSR_YOFF:   shadow_y <= wd[DIM_W-1:0];
                    default: ;
                endcase
            end

            // A new frame-done event beats a simultaneous write-1-to-clear.
            if (frame_done && (state != STOPPED))
                irq_frame <= 1'b1;
            else if (wr_acc && (byte_addr == CSR_IRQ) && wd[IRQ_FRAME])
                irq_frame <= 1'b0;
        end
    end

    // Run-state machine with registered commit outputs. Any frame_start with
    // GO set commits and runs, whatever the current state; with GO clear the
    // pipeline gets one drain frame (STOPPING) before go drops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= STOPPED;
            go            <= 1'b0;
            active_width  <= '0;
            active_height <= '0;
            active_x      <= '0;
            active_y      <= '0;
        end else if (frame_start) begin
            if (ctrl_go) begin
                state         <= RUNNING;
                go            <= 1'b1;
                active_width  <= shadow_w;
                active_height <= shadow_h;
                active_x      <= shadow_x;
                active_y      <= shadow_y;
            end else begin
                case (state)
                    RUNNING:  state <= STOPPING;
                    STOPPING: begin
                        state <= STOPPED;
                        go    <= 1'b0;
                    end
                    default:  state <= STOPPED;
                endcase
            end
        end
    end

    csr_read_pipe #(
        .DEPTH  (READ_LATENCY),
        .DATA_W (32)
    ) u_read_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (rd_acc),
        .in_data   (rd_mux),
        .out_valid (bus.amm_readdatavalid),
        .out_data  (bus.amm_readdata)
    );
endmodule
`default_nettype wire
